seq_divider: RTL and testbench

//   Iterative restoring divider: the inverse of the pipelined 8x8 wallace multiplier.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 38 +++
 rtl/seq_divider.sv | 120 ++++++++++++
 tb/tb_seq_divider.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// +------------------------------------------------------------------+
// | div_pkg: shared state encoding and default widths for the divider |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package div_pkg;

  localparam int DIV_DW = 16;
  localparam int DIV_VW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// +------------------------------------------------------------------+
// | div_step: one restoring compare/subtract/shift step               |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module div_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   r,
  input  logic          qmsb,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   r_next,
  output logic          qbit
);

  logic [VW:0] t;
  logic [VW:0] d_ext;
  // The top bit of r is always 0 between steps; it is shifted out here.
  logic        unused_rmsb;

  assign unused_rmsb = r[VW];

  always_comb begin
    t     = {r[VW-1:0], qmsb};
    d_ext = {1'b0, divisor};
    if (t >= d_ext) begin
      r_next = t - d_ext;
      qbit   = 1'b1;
    end else begin
      r_next = t;
      qbit   = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// +------------------------------------------------------------------+
// | seq_divider: iterative restoring divider, start/busy/done handshake |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module seq_divider
  import div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz
);

  localparam int            CW   = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  div_state_e    state_q, state_d;
  logic [VW:0]   r_q, r_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   step_r;
  logic          step_qbit;

  div_step #(.VW(VW)) u_step (
    .r       (r_q),
    .qmsb    (q_q[DW-1]),
    .divisor (div_q),
    .r_next  (step_r),
    .qbit    (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          q_d     = dividend;
          div_d   = divisor;
          r_d     = '0;
          cnt_d   = '0;
          state_d = (divisor == '0) ? ZERO : RUN;
        end
      end
      RUN: begin
        r_d   = step_r;
        q_d   = {q_q[DW-2:0], step_qbit};
        cnt_d = cnt_q + 1'b1;
        // Results are published only on the last step so the old result stays visible.
        if (cnt_q == LAST) begin
          state_d = DONE;
          quot_d  = {q_q[DW-2:0], step_qbit};
          rem_d   = step_r[VW-1:0];
          dbz_d   = 1'b0;
        end
      end
      ZERO: begin
        state_d = DONE;
        quot_d  = '1;
        rem_d   = q_q[VW-1:0];
        dbz_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == ZERO);
  assign done      = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// +------------------------------------------------------------------+
// | tb_seq_divider: directed and randomised checks of seq_divider     |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        dbz;

  int pass_cnt  = 0;
  int total_cnt = 0;

  seq_divider dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Drive one operation and count edges (including the sampling edge) until done.
  task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs, output int lat);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    lat      = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (done) break;
    end
    if (!done) lat = 99;
  endtask

  task automatic check_op(input string name, input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [15:0] exp_q, input logic [7:0] exp_r,
                          input logic exp_dbz, input int exp_lat);
    int lat;
    run_op(dvd, dvs, lat);
    total_cnt++;
    if (lat !== exp_lat || quotient !== exp_q || remainder !== exp_r || dbz !== exp_dbz)
      $display("FAIL %s: got lat=%0d q=%0d r=%0d dbz=%0b required lat=%0d q=%0d r=%0d dbz=%0b",
               name, lat, quotient, remainder, dbz, exp_lat, exp_q, exp_r, exp_dbz);
    else
      pass_cnt++;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, done, quotient, remainder, dbz} !== '0)
      $display("FAIL reset_state: got busy=%0b done=%0b q=%0d r=%0d dbz=%0b required all 0",
               busy, done, quotient, remainder, dbz);
    else
      pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_round_trip;
    check_op("rt_165_55", 16'd165, 8'd55, 16'd3, 8'd0, 1'b0, 17);
    check_op("rt_46436_188", 16'd46436, 8'd188, 16'd247, 8'd0, 1'b0, 17);
  endtask

  task automatic test_mid_run_reset;
    int ndone;
    @(negedge clk);
    dividend = 16'd12614;
    divisor  = 8'd106;
    start    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL midrst_busy_before: got busy=%0b required 1", busy);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, quotient, remainder, dbz} !== '0)
      $display("FAIL midrst_outputs: got busy=%0b done=%0b q=%0d r=%0d dbz=%0b required all 0",
               busy, done, quotient, remainder, dbz);
    else
      pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    total_cnt++;
    if (ndone !== 0) $display("FAIL midrst_no_done: got %0d active cycles required 0", ndone);
    else pass_cnt++;
    check_op("midrst_restart", 16'd12614, 8'd106, 16'd119, 8'd0, 1'b0, 17);
  endtask

  task automatic test_remainder;
    check_op("rem_12615_106", 16'd12615, 8'd106, 16'd119, 8'd1, 1'b0, 17);
    check_op("ext_65535_1", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 17);
    check_op("ext_65535_255", 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 17);
    check_op("small_5_7", 16'd5, 8'd7, 16'd0, 8'd5, 1'b0, 17);
  endtask

  task automatic test_div_zero;
    check_op("dbz_1000_0", 16'd1000, 8'd0, 16'hFFFF, 8'hE8, 1'b1, 2);
    check_op("dbz_cleared", 16'd165, 8'd55, 16'd3, 8'd0, 1'b0, 17);
  endtask

  task automatic test_start_ignored;
    int lat;
    int bad;
    int extra;
    check_op("ign_pre", 16'd5, 8'd7, 16'd0, 8'd5, 1'b0, 17);
    @(negedge clk);
    dividend = 16'd46436;
    divisor  = 8'd188;
    start    = 1'b1;
    lat = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (done) break;
      if (quotient !== 16'd0 || remainder !== 8'd5 || !busy) bad++;
      if (lat == 5) begin
        dividend = 16'd100;
        divisor  = 8'd3;
        start    = 1'b1;
      end
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL ign_old_result_held: got %0d bad cycles required 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 17 || quotient !== 16'd247 || remainder !== 8'd0)
      $display("FAIL ign_result: got lat=%0d q=%0d r=%0d required lat=17 q=247 r=0",
               lat, quotient, remainder);
    else
      pass_cnt++;
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    total_cnt++;
    if (extra !== 0) $display("FAIL ign_no_rerun: got %0d active cycles required 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat;
    int ndone;
    run_op(16'd12615, 8'd106, lat);
    // Still inside the DONE cycle: request the next op immediately.
    dividend = 16'd165;
    divisor  = 8'd55;
    start    = 1'b1;
    total_cnt++;
    if (lat !== 17 || quotient !== 16'd119 || remainder !== 8'd1)
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d required lat=17 q=119 r=1",
               lat, quotient, remainder);
    else
      pass_cnt++;
    @(posedge clk);
    #1;
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_busy: got busy=%0b done=%0b required busy=1 done=0", busy, done);
    else
      pass_cnt++;
    lat = 1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (ndone == 0) lat++;
      if (done) begin
        ndone++;
        total_cnt++;
        if (quotient !== 16'd3 || remainder !== 8'd0)
          $display("FAIL b2b_second: got q=%0d r=%0d required q=3 r=0", quotient, remainder);
        else
          pass_cnt++;
      end
    end
    total_cnt++;
    if (ndone !== 1 || lat !== 17)
      $display("FAIL b2b_done_count: got dones=%0d lat=%0d required dones=1 lat=17", ndone, lat);
    else
      pass_cnt++;
  endtask

  task automatic test_random;
    int lat;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    int unsigned prod;
    for (int n = 0; n < 200; n++) begin
      dvd = 16'($urandom);
      dvs = 8'($urandom_range(255, 1));
      run_op(dvd, dvs, lat);
      prod = quotient * dvs + remainder;
      total_cnt++;
      if (lat !== 17 || prod !== 32'(dvd) || remainder >= dvs || dbz !== 1'b0)
        $display("FAIL rand_%0d: %0d/%0d got q=%0d r=%0d lat=%0d dbz=%0b required q*d+r=%0d r<d lat=17 dbz=0",
                 n, dvd, dvs, quotient, remainder, lat, dbz, dvd);
      else
        pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_mid_run_reset();
    test_remainder();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
